// File: rtl/tnoc_vc_merge_pkg.sv
// rtl/tnoc_vc_merge_pkg.sv - shared types and round-robin pick function for the VC merger
package tnoc_vc_merge_pkg;

    localparam int TNOC_MAX_CHANNELS = 32;
    localparam int TNOC_MAX_VC_WIDTH = 5;

    typedef enum logic [0:0] {
        TNOC_MERGE_IDLE   = 1'b0,
        TNOC_MERGE_LOCKED = 1'b1
    } tnoc_merge_state_e;

    typedef struct packed {
        logic                         found;
        logic [TNOC_MAX_VC_WIDTH-1:0] idx;
    } tnoc_rr_pick_t;

    // First requester after ptr, searching ptr+1, ptr+2, ... with wrap modulo channels.
    function automatic tnoc_rr_pick_t tnoc_rr_select(
        input logic [TNOC_MAX_CHANNELS-1:0] req,
        input int unsigned                  ptr,
        input int unsigned                  channels
    );
        tnoc_rr_pick_t pick;
        int unsigned   cand;
        pick = '0;
        for (int unsigned i = 1; i <= TNOC_MAX_CHANNELS; i++) begin
            if ((i <= channels) && !pick.found) begin
                cand = (ptr + i) % channels;
                if (req[cand[TNOC_MAX_VC_WIDTH-1:0]]) begin
                    pick.found = 1'b1;
                    pick.idx   = TNOC_MAX_VC_WIDTH'(cand);
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/tnoc_rr_arbiter.sv
// rtl/tnoc_rr_arbiter.sv - round-robin arbiter with grant hold until the grant is consumed
module tnoc_rr_arbiter
    import tnoc_vc_merge_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int VC_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] req,
    input  logic                update,
    output logic [CHANNELS-1:0] grant_onehot,
    output logic [VC_WIDTH-1:0] grant_idx,
    output logic                grant_valid
);

    logic [VC_WIDTH-1:0]          rr_ptr_q;
    logic                         hold_q;
    logic [VC_WIDTH-1:0]          hold_idx_q;
    logic                         hold_eff;
    logic [TNOC_MAX_CHANNELS-1:0] req_ext;
    tnoc_rr_pick_t                pick;

    // Grant selection: a presented-but-unaccepted grant stays put while its requester is still asking.
    always_comb begin
        req_ext                 = '0;
        req_ext[CHANNELS-1:0]   = req;
        pick                    = tnoc_rr_select(req_ext, 32'(rr_ptr_q), 32'(CHANNELS));
        hold_eff                = hold_q && req[hold_idx_q];
        grant_valid             = hold_eff || pick.found;
        grant_idx               = hold_eff ? hold_idx_q : VC_WIDTH'(pick.idx);
        grant_onehot            = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            grant_onehot[c] = grant_valid && (grant_idx == VC_WIDTH'(c));
        end
    end

    // Pointer advances only on a consumed grant; otherwise remember what was presented.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q   <= VC_WIDTH'(CHANNELS - 1);
            hold_q     <= 1'b0;
            hold_idx_q <= '0;
        end else if (update) begin
            rr_ptr_q   <= grant_idx;
            hold_q     <= 1'b0;
        end else begin
            hold_q     <= grant_valid;
            hold_idx_q <= grant_idx;
        end
    end

endmodule

// File: rtl/tnoc_flit_vc_merger.sv
// rtl/tnoc_flit_vc_merger.sv - packet-granular round-robin merge of per-VC flit streams onto one link
module tnoc_flit_vc_merger
    import tnoc_vc_merge_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int FLIT_WIDTH = 64,
    parameter int VC_WIDTH   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [CHANNELS-1:0]            i_valid,
    output logic [CHANNELS-1:0]            o_ready,
    input  logic [CHANNELS-1:0]            i_head,
    input  logic [CHANNELS-1:0]            i_tail,
    input  logic [CHANNELS*FLIT_WIDTH-1:0] i_flit,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic                           o_head,
    output logic                           o_tail,
    output logic [FLIT_WIDTH-1:0]          o_flit,
    output logic [VC_WIDTH-1:0]            o_vc
);

    tnoc_merge_state_e   state_q;
    tnoc_merge_state_e   state_d;
    logic [VC_WIDTH-1:0] lock_vc_q;

    logic [CHANNELS-1:0] arb_req;
    logic [CHANNELS-1:0] grant_onehot;
    logic [VC_WIDTH-1:0] grant_idx;
    logic                grant_valid;
    logic                arb_update;

    logic [VC_WIDTH-1:0]   sel;
    logic                  sel_valid;
    logic                  sel_head;
    logic                  sel_tail;
    logic [FLIT_WIDTH-1:0] sel_flit;
    logic                  active;
    logic                  xfer;

    // Only head flits compete, and only while no packet owns the link.
    always_comb begin
        arb_req    = (state_q == TNOC_MERGE_IDLE) ? (i_valid & i_head) : '0;
        arb_update = (state_q == TNOC_MERGE_IDLE) && xfer;
    end

    tnoc_rr_arbiter #(
        .CHANNELS (CHANNELS),
        .VC_WIDTH (VC_WIDTH)
    ) u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (arb_req),
        .update       (arb_update),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .grant_valid  (grant_valid)
    );

    // State register plus the owning channel captured on a non-tail head transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= TNOC_MERGE_IDLE;
            lock_vc_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == TNOC_MERGE_IDLE) && xfer && !sel_tail) begin
                lock_vc_q <= sel;
            end
        end
    end

    // Next state: a multi-flit head locks the link, its tail releases it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TNOC_MERGE_IDLE:   if (xfer && !sel_tail) state_d = TNOC_MERGE_LOCKED;
            TNOC_MERGE_LOCKED: if (xfer && sel_tail)  state_d = TNOC_MERGE_IDLE;
            default:           state_d = TNOC_MERGE_IDLE;
        endcase
    end

    // Output mux: owner channel when locked, arbiter grant when idle; everything quiet in reset.
    always_comb begin
        sel       = (state_q == TNOC_MERGE_LOCKED) ? lock_vc_q : grant_idx;
        sel_valid = 1'b0;
        sel_head  = 1'b0;
        sel_tail  = 1'b0;
        sel_flit  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (sel == VC_WIDTH'(c)) begin
                sel_valid = i_valid[c];
                sel_head  = i_head[c];
                sel_tail  = i_tail[c];
                sel_flit  = i_flit[c*FLIT_WIDTH +: FLIT_WIDTH];
            end
        end
        active  = rst_n && ((state_q == TNOC_MERGE_LOCKED) ? sel_valid : grant_valid);
        xfer    = active && i_ready;
        o_valid = active;
        o_head  = active && sel_head;
        o_tail  = active && sel_tail;
        o_flit  = active ? sel_flit : '0;
        o_vc    = active ? sel : '0;
        o_ready = '0;
        if (rst_n && i_ready) begin
            if (state_q == TNOC_MERGE_LOCKED) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    o_ready[c] = (lock_vc_q == VC_WIDTH'(c));
                end
            end else begin
                o_ready = grant_onehot;
            end
        end
    end

    // Protocol checks: body flits without an owner, and a new head inside an owned packet.
    idle_body_flit: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == TNOC_MERGE_IDLE) |-> ((i_valid & ~i_head) == '0));

    locked_head_flit: assert property (@(posedge clk) disable iff (!rst_n)
        ((state_q == TNOC_MERGE_LOCKED) && sel_valid) |-> !sel_head);

endmodule
